// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared state type, width defaults and select-width helper for freq_meas_sched
package freq_meas_pkg;

   localparam int CNT_W_DEF  = 32;
   localparam int GATE_W_DEF = 32;
   localparam int TMR_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_STORE  = 3'd5,
      ST_NEXT   = 3'd6
   } fms_state_t;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_next_ch.sv
// rtl/rr_next_ch.sv - finds the lowest set mask bit at an index >= i_from, flags when none remain
module rr_next_ch #(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic [N_CH-1:0]  i_mask,
   input  logic [SEL_W:0]   i_from,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_none
);

   // i_from is one bit wider than an index so that "pointer+1" past the last channel cannot wrap to 0
   always_comb begin
      o_idx  = '0;
      o_none = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i >= int'(i_from))) begin
            o_idx  = SEL_W'(i);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/freq_meas_sched.sv
// rtl/freq_meas_sched.sv - sweeps one frequency-measurement datapath across N_CH clocks; FREQ_SCHED_TIMEOUT_EN adds a WAIT watchdog
module freq_meas_sched
   import freq_meas_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int CNT_W          = CNT_W_DEF,
   parameter int GATE_W         = GATE_W_DEF,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 200000000
) (
   input  logic                      clk100,
   input  logic                      reset,
   input  logic [N_CH-1:0]           ch_enable,
   input  logic [GATE_W-1:0]         gate_cycles,
   input  logic                      continuous,
   input  logic                      start,
   input  logic                      abort,
   output logic [$clog2(N_CH)-1:0]   meas_sel,
   output logic [GATE_W-1:0]         meas_gate,
   output logic                      meas_start,
   input  logic                      meas_done,
   input  logic [CNT_W-1:0]          meas_count,
   output logic                      res_valid,
   output logic [$clog2(N_CH)-1:0]   res_ch,
   output logic [CNT_W-1:0]          res_count,
   output logic                      res_err,
   output logic                      busy,
   output logic                      sweep_done
);

   localparam int SEL_W       = sel_width(N_CH);
   localparam int SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 0 : SETTLE_CYCLES - 1;
   localparam int TO_LAST     = (TIMEOUT_CYCLES <= 1) ? 0 : TIMEOUT_CYCLES - 1;
`ifdef FREQ_SCHED_TIMEOUT_EN
   localparam bit TIMEOUT_EN  = 1'b1;
`else
   localparam bit TIMEOUT_EN  = 1'b0;
`endif

   fms_state_t         r_state;
   fms_state_t         w_state_nxt;
   logic [N_CH-1:0]    r_en;
   logic [GATE_W-1:0]  r_gate;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [TMR_W-1:0]   r_cnt;
   logic [SEL_W-1:0]   r_res_ch;
   logic [CNT_W-1:0]   r_res_count;
   logic               r_res_err;
   logic               r_sweep_done;

   logic [SEL_W:0]     w_from;
   logic [SEL_W-1:0]   w_idx;
   logic               w_none;
   logic               w_settle_last;
   logic               w_timeout;
   logic [GATE_W-1:0]  w_gate_lat;

   // NEXT asks "anything above the pointer"; SELECT asks "anything at or above it"
   assign w_from = (r_state == ST_NEXT) ? ({1'b0, r_ptr} + (SEL_W+1)'(1)) : {1'b0, r_ptr};

   rr_next_ch #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_next_ch (
      .i_mask (r_en),
      .i_from (w_from),
      .o_idx  (w_idx),
      .o_none (w_none)
   );

   assign w_settle_last = (r_cnt == TMR_W'(SETTLE_LAST));
   assign w_timeout     = TIMEOUT_EN && (r_cnt == TMR_W'(TO_LAST));
   assign w_gate_lat    = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

   // State register
   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; abort overrides everything, including a simultaneous start
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (start && (ch_enable != '0)) w_state_nxt = ST_SELECT;
            ST_SELECT: w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_settle_last) w_state_nxt = ST_START;
            ST_START:  w_state_nxt = ST_WAIT;
            ST_WAIT:   if (meas_done || w_timeout) w_state_nxt = ST_STORE;
            ST_STORE:  w_state_nxt = ST_NEXT;
            ST_NEXT: begin
               if (!w_none) begin
                  w_state_nxt = ST_SELECT;
               end else if (continuous && (ch_enable != '0)) begin
                  w_state_nxt = ST_SELECT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Sweep bookkeeping: latched config, channel pointer, shared settle/watchdog timer, result capture
   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         r_en         <= '0;
         r_gate       <= '0;
         r_ptr        <= '0;
         r_sel        <= '0;
         r_cnt        <= '0;
         r_res_ch     <= '0;
         r_res_count  <= '0;
         r_res_err    <= 1'b0;
         r_sweep_done <= 1'b0;
      end else begin
         r_sweep_done <= 1'b0;
         if (!abort) begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     if (ch_enable != '0) begin
                        r_en   <= ch_enable;
                        r_gate <= w_gate_lat;
                        r_ptr  <= '0;
                     end else begin
                        r_sweep_done <= 1'b1;
                     end
                  end
               end
               ST_SELECT: begin
                  r_ptr <= w_idx;
                  r_sel <= w_idx;
                  r_cnt <= '0;
               end
               ST_SETTLE: r_cnt <= r_cnt + TMR_W'(1);
               ST_START:  r_cnt <= '0;
               ST_WAIT: begin
                  r_cnt <= r_cnt + TMR_W'(1);
                  if (meas_done) begin
                     r_res_ch    <= r_ptr;
                     r_res_count <= meas_count;
                     r_res_err   <= 1'b0;
                  end else if (w_timeout) begin
                     r_res_ch    <= r_ptr;
                     r_res_count <= '0;
                     r_res_err   <= 1'b1;
                  end
               end
               ST_NEXT: begin
                  if (!w_none) begin
                     r_ptr <= r_ptr + SEL_W'(1);
                  end else begin
                     r_sweep_done <= 1'b1;
                     if (continuous) begin
                        r_en   <= ch_enable;
                        r_gate <= w_gate_lat;
                        r_ptr  <= '0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign meas_sel   = r_sel;
   assign meas_gate  = r_gate;
   assign meas_start = (r_state == ST_START) && !abort;
   assign res_valid  = (r_state == ST_STORE) && !abort;
   assign res_ch     = r_res_ch;
   assign res_count  = r_res_count;
   assign res_err    = TIMEOUT_EN ? r_res_err : 1'b0;
   assign busy       = (r_state != ST_IDLE);
   assign sweep_done = r_sweep_done;

endmodule

// File: doc/freq_meas_sched.md
Name: freq_meas_sched

Overview:
Sequencer that time-shares one frequency-measurement datapath between N_CH candidate input clocks. It drives the datapath's input-clock select, gate length and start, then collects each count. Results go out as one-cycle tagged records for the slave-register block to capture. Runs single sweeps on request or continuous sweeps, entirely in the clk100 domain.

Parameters:
N_CH, 4, number of measurable input clocks (2..16)
CNT_W, 32, width of measured count and result
GATE_W, 32, width of gate-length configuration (clk100 cycles)
SETTLE_CYCLES, 16, clk100 cycles to wait after changing meas_sel before start
TIMEOUT_CYCLES, 200000000, WAIT watchdog limit (used only with the optional feature)

Ports:
clk100  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
ch_enable  in  N_CH  channels to include in a sweep
gate_cycles  in  GATE_W  gate window length in clk100 cycles
continuous  in  1  1 = restart a sweep automatically after sweep_done
start  in  1  one-cycle sweep request
abort  in  1  one-cycle abort request
meas_sel  out  $clog2(N_CH)  input-clock mux select to datapath
meas_gate  out  GATE_W  gate length to datapath
meas_start  out  1  one-cycle start pulse to datapath
meas_done  in  1  one-cycle pulse, meas_count valid
meas_count  in  CNT_W  count from datapath
res_valid  out  1  one-cycle result strobe
res_ch  out  $clog2(N_CH)  channel of result
res_count  out  CNT_W  measured count
res_err  out  1  result is a timeout, not a measurement
busy  out  1  high in any state except IDLE
sweep_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, all outputs 0, channel pointer 0, latched enable/gate 0.
- States: IDLE, SELECT, SETTLE, START, WAIT, STORE, NEXT.
- IDLE:
  - start=1 and ch_enable!=0: latch ch_enable and gate_cycles (gate 0 is latched as 1), pointer=0, go to SELECT.
  - start=1 and ch_enable==0: pulse sweep_done next cycle, stay IDLE.
- SELECT (1 cycle): pointer := lowest latched-enabled index >= pointer. Drive meas_sel to it. Go to SETTLE.
- SETTLE: counts SETTLE_CYCLES clk100 cycles, then goes to START. SETTLE_CYCLES=0 means a 1-cycle pass-through.
- START (1 cycle): meas_start=1, meas_gate holds the latched gate. Go to WAIT.
- WAIT: on meas_done, capture meas_count and go to STORE. meas_done in any other state is ignored.
- STORE (1 cycle): res_valid=1, res_ch=pointer, res_count=captured value, res_err=0. Go to NEXT.
- NEXT:
  - If a latched-enabled index > pointer exists: pointer+1, go to SELECT.
  - Otherwise pulse sweep_done.
    - continuous=1: relatch ch_enable and gate, pointer=0, go to SELECT.
    - continuous=0: go to IDLE.
  - If continuous=1 but the new ch_enable==0, go to IDLE after sweep_done.
- res_* hold their values between strobes. res_valid is never high for two consecutive cycles.
- abort (any state, highest priority): IDLE next cycle; meas_start forced 0; no res_valid and no sweep_done generated. abort and start together: abort wins.
- start while busy: ignored.
- ch_enable and gate_cycles changes mid-sweep: no effect until the next latch.
- Latency for one channel, start to res_valid: 1+SETTLE_CYCLES+1+1+(datapath)+1 cycles.

Optional Feature:
FREQ_SCHED_TIMEOUT_EN.
- Defined: a WAIT watchdog counts clk100 cycles. After TIMEOUT_CYCLES with no meas_done, go to STORE with res_err=1 and res_count=0, then the sweep continues normally. The watchdog clears on WAIT entry.
- Undefined: WAIT has no limit (only abort exits it). res_err is tied 0 and TIMEOUT_CYCLES is unused.

Decomposition:
- Package freq_meas_pkg: state enum, CNT_W/GATE_W defaults, select-width helper constant.
- One sub-module, rr_next_ch: combinational "lowest set bit at index >= pointer" finder that also flags "none remaining". It is used by SELECT and NEXT.

Test Plan:
- SETTLE_CYCLES=2, ch_enable=4'b0101, gate=1000, start; model answers meas_done with count=ch*100 → two res_valid (ch0/0, ch2/200), then sweep_done, busy drops, meas_sel visits only 0 and 2.
- continuous=1, ch_enable=4'b1000, 3 sweeps → res_ch=3 three times, sweep_done three times, never IDLE between sweeps; clear continuous → IDLE after the current sweep.
- abort asserted in WAIT and in SETTLE → IDLE next cycle, no res_valid, no sweep_done; late meas_done ignored; a new start works.
- start with ch_enable=0 → sweep_done one cycle later, busy stays 0; gate_cycles=0 → meas_gate=1.
- FREQ_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, model silent on ch1 → res_valid with res_err=1, res_count=0 after 50 WAIT cycles, then ch2 measured normally.
- Asynchronous reset pulse mid-WAIT (between clock edges) → all outputs 0 immediately; start after release begins a sweep at ch0.
